// File: rtl/imem_tag_responder_if.sv
// Command/response/completion bus between a requester and imem_tag_responder,
// plus the preload port used to seed the backing store.
`ifndef XLEN
`define XLEN 32
`endif

interface imem_tag_responder_if #(
   parameter int MEM_LINES = 1024
);
   localparam int IDX_W = $clog2(MEM_LINES);

   logic [1:0]        proc2mem_command;
   logic [`XLEN-1:0]  proc2mem_addr;
   logic [63:0]       proc2mem_data;
   logic              init_we;
   logic [IDX_W-1:0]  init_addr;
   logic [63:0]       init_data;
   logic [3:0]        mem2proc_response;
   logic [63:0]       mem2proc_data;
   logic [3:0]        mem2proc_tag;

   modport master (
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      output init_we, init_addr, init_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag
   );

   modport slave (
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      input  init_we, init_addr, init_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag
   );
endinterface

// File: rtl/imem_tag_responder.sv
// Tagged load/store memory responder with fixed-latency in-order completions.
// Optional MEM_REJECT_EN adds LFSR-driven pseudo-random command rejection.
module imem_tag_responder #(
   parameter int LATENCY   = 10,
   parameter int MEM_LINES = 1024
) (
   input logic                 clock,
   input logic                 reset,
   imem_tag_responder_if.slave bus
);
   localparam int IDX_W = $clog2(MEM_LINES);
   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   logic [63:0]      mem [MEM_LINES];
   logic [14:0]      free_mask;
   logic [14:0]      done_bit;
   logic [14:0]      alloc_bit;
   logic [3:0]       alloc_tag;
   logic             reject_now;
   logic             accept;
   logic             load_acc;
   logic             store_acc;
   logic [IDX_W-1:0] line_idx;
   logic [63:0]      rd_data;
   logic             unused_addr_bits;

   logic [LATENCY-1:0] vld_p;
   logic [3:0]         tag_p  [LATENCY];
   logic [63:0]        data_p [LATENCY];

`ifdef MEM_REJECT_EN
   logic [7:0] lfsr;

   always_ff @(posedge clock) begin
      if (reset) lfsr <= 8'hA5;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign reject_now = (lfsr[1:0] == 2'b00);
`else
   assign reject_now = 1'b0;
`endif

   assign line_idx         = bus.proc2mem_addr[3 +: IDX_W];
   assign unused_addr_bits = ^{bus.proc2mem_addr[`XLEN-1:3+IDX_W], bus.proc2mem_addr[2:0]};
   assign rd_data          = mem[line_idx];

   // Lowest-numbered free tag; 0 when every tag is in flight.
   always_comb begin
      alloc_tag = 4'd0;
      for (int i = 14; i >= 0; i--) begin
         if (free_mask[i]) alloc_tag = 4'(i + 1);
      end
   end

   assign accept    = !reset && (bus.proc2mem_command != BUS_NONE) && (free_mask != 15'd0) && !reject_now;
   assign load_acc  = accept && (bus.proc2mem_command == BUS_LOAD);
   assign store_acc = accept && (bus.proc2mem_command == BUS_STORE);
   assign bus.mem2proc_response = accept ? alloc_tag : 4'd0;

   // The completing tag stays busy for its whole completion cycle, so a load
   // accepted in that same cycle can never be handed it.
   always_comb begin
      done_bit  = '0;
      alloc_bit = '0;
      if (vld_p[LATENCY-1]) done_bit[tag_p[LATENCY-1] - 4'd1] = 1'b1;
      if (load_acc)         alloc_bit[alloc_tag - 4'd1]       = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) free_mask <= 15'h7FFF;
      else       free_mask <= (free_mask | done_bit) & ~alloc_bit;
   end

   // Delay line: stage 0 captures the accepted load, last stage drives the outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_p <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            tag_p[i]  <= 4'd0;
            data_p[i] <= 64'd0;
         end
      end else begin
         vld_p[0]  <= load_acc;
         tag_p[0]  <= load_acc ? alloc_tag : 4'd0;
         data_p[0] <= load_acc ? rd_data : 64'd0;
         for (int i = 1; i < LATENCY; i++) begin
            vld_p[i]  <= vld_p[i-1];
            tag_p[i]  <= tag_p[i-1];
            data_p[i] <= data_p[i-1];
         end
      end
   end

   assign bus.mem2proc_tag  = tag_p[LATENCY-1];
   assign bus.mem2proc_data = data_p[LATENCY-1];

   // Store is written after init so a same-line, same-cycle store wins.
   always_ff @(posedge clock) begin
      if (bus.init_we) mem[bus.init_addr] <= bus.init_data;
      if (store_acc)   mem[line_idx]      <= bus.proc2mem_data;
   end
endmodule

// File: tb/tb_imem_tag_responder.sv
// Bench for imem_tag_responder: two instances (latency 10 and 20) share one stimulus stream.
`timescale 1ns/1ps
module tb_imem_tag_responder;
   localparam int LAT_A = 10;
   localparam int LAT_B = 20;
   localparam int MEM_LINES = 1024;
   localparam int IDX_W = 10;
   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [1:0]       cmd;
   logic [31:0]      addr;
   logic [63:0]      wdata;
   logic             init_we;
   logic [IDX_W-1:0] init_addr;
   logic [63:0]      init_data;

   imem_tag_responder_if #(.MEM_LINES(MEM_LINES)) bus_a ();
   imem_tag_responder_if #(.MEM_LINES(MEM_LINES)) bus_b ();

   assign bus_a.proc2mem_command = cmd;
   assign bus_a.proc2mem_addr    = addr;
   assign bus_a.proc2mem_data    = wdata;
   assign bus_a.init_we          = init_we;
   assign bus_a.init_addr        = init_addr;
   assign bus_a.init_data        = init_data;
   assign bus_b.proc2mem_command = cmd;
   assign bus_b.proc2mem_addr    = addr;
   assign bus_b.proc2mem_data    = wdata;
   assign bus_b.init_we          = init_we;
   assign bus_b.init_addr        = init_addr;
   assign bus_b.init_data        = init_data;

   imem_tag_responder #(.LATENCY(LAT_A), .MEM_LINES(MEM_LINES)) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a));
   imem_tag_responder #(.LATENCY(LAT_B), .MEM_LINES(MEM_LINES)) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard / reference model ----------------
   typedef struct {
      int          due;
      logic [3:0]  tag;
      logic [63:0] data;
   } exp_t;

   exp_t        sbq [2][$];
   logic [14:0] free_m [2];
   logic [63:0] mem_m [2][int];
   int          lat_m [2] = '{LAT_A, LAT_B};
   logic [7:0]  lfsr_m;

   logic [3:0]  m_er, m_rt, m_ct, m_at;
   logic [63:0] m_ad;
   int          m_line;

   function automatic logic reject_m();
`ifdef MEM_REJECT_EN
      return lfsr_m[1:0] == 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] model_resp(input int k);
      if (reset || cmd == BUS_NONE || reject_m()) return 4'd0;
      for (int t = 1; t <= 15; t++) begin
         if (free_m[k][t-1]) return 4'(t);
      end
      return 4'd0;
   endfunction

   always @(negedge clock) begin
      m_line = int'((addr >> 3) & 32'(MEM_LINES - 1));
      for (int k = 0; k < 2; k++) begin
         m_er = model_resp(k);
         m_rt = (k == 0) ? bus_a.mem2proc_response : bus_b.mem2proc_response;
         m_at = (k == 0) ? bus_a.mem2proc_tag : bus_b.mem2proc_tag;
         m_ad = (k == 0) ? bus_a.mem2proc_data : bus_b.mem2proc_data;
         check(k == 0 ? "resp_a" : "resp_b", m_rt, m_er);
         m_ct = 4'd0;
         if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
            m_ct = sbq[k][0].tag;
            check(k == 0 ? "cmpl_tag_a" : "cmpl_tag_b", m_at, sbq[k][0].tag);
            check(k == 0 ? "cmpl_data_a" : "cmpl_data_b", m_ad, sbq[k][0].data);
            void'(sbq[k].pop_front());
         end else begin
            check(k == 0 ? "idle_tag_a" : "idle_tag_b", m_at, 64'd0);
         end
         if (reset) begin
            free_m[k] = 15'h7FFF;
            sbq[k].delete();
         end else begin
            if (m_ct != 4'd0) free_m[k][m_ct - 4'd1] = 1'b1;
            if (m_er != 4'd0 && cmd == BUS_LOAD) begin
               free_m[k][m_er - 4'd1] = 1'b0;
               sbq[k].push_back('{cyc + lat_m[k], m_er,
                                  mem_m[k].exists(m_line) ? mem_m[k][m_line] : 64'd0});
            end
         end
         if (init_we) mem_m[k][int'(init_addr)] = init_data;
         if (m_er != 4'd0 && cmd == BUS_STORE) mem_m[k][m_line] = wdata;
      end
      if (reset) lfsr_m = 8'hA5;
      else       lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   end

   // ---------------- directed vector table ----------------
   typedef struct {
      logic             rst;
      logic [1:0]       cmd;
      logic [31:0]      addr;
      logic [63:0]      data;
      logic             iwe;
      logic [IDX_W-1:0] iaddr;
      logic [63:0]      idata;
      logic [3:0]       exp_a;
      logic [3:0]       exp_b;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic [1:0] c, input logic [31:0] a,
                               input logic [63:0] d, input logic [3:0] ea, input logic [3:0] eb);
      tbl.push_back('{r, c, a, d, 1'b0, '0, 64'd0, ea, eb});
   endfunction

   function automatic void idle(input int n);
      for (int i = 0; i < n; i++) add(1'b0, BUS_NONE, 32'd0, 64'd0, 4'd0, 4'd0);
   endfunction

   initial begin
      vec_t v;
      cmd = BUS_NONE; addr = 32'd0; wdata = 64'd0;
      init_we = 1'b0; init_addr = '0; init_data = 64'd0;
      reset = 1'b1;

      // single load of a preloaded line
      add(1'b1, BUS_NONE, 32'd0, 64'd0, 4'd0, 4'd0);
      idle(5);
      add(1'b0, BUS_LOAD, 32'h18, 64'd0, 4'd1, 4'd1);
      idle(21);
      // back-to-back loads; latency-10 instance reuses tag 1 once it is freed
      add(1'b1, BUS_NONE, 32'd0, 64'd0, 4'd0, 4'd0);
      for (int i = 0; i < 12; i++)
         add(1'b0, BUS_LOAD, 32'(i * 8), 64'd0, (i < 11) ? 4'(i + 1) : 4'd1, 4'(i + 1));
      add(1'b0, BUS_LOAD, 32'h60, 64'd0, 4'd2, 4'd13);
      idle(22);
      // tag exhaustion on the latency-20 instance
      add(1'b1, BUS_NONE, 32'd0, 64'd0, 4'd0, 4'd0);
      for (int i = 0; i < 16; i++)
         add(1'b0, BUS_LOAD, 32'(i * 8), 64'd0, (i <= 10) ? 4'(i + 1) : 4'(i - 10),
             (i < 15) ? 4'(i + 1) : 4'd0);
      idle(4);
      add(1'b0, BUS_LOAD, 32'h20, 64'd0, 4'd6, 4'd0);
      add(1'b0, BUS_LOAD, 32'h28, 64'd0, 4'd7, 4'd1);
      idle(25);
      // stores, store/load ordering, store beating init, upper address bits ignored
      add(1'b1, BUS_NONE, 32'd0, 64'd0, 4'd0, 4'd0);
      add(1'b0, BUS_STORE, 32'h40, 64'h1234, 4'd1, 4'd1);
      add(1'b0, BUS_LOAD,  32'h40, 64'd0, 4'd1, 4'd1);
      add(1'b0, BUS_LOAD,  32'h48, 64'd0, 4'd2, 4'd2);
      add(1'b0, BUS_STORE, 32'h48, 64'h5555, 4'd3, 4'd3);
      add(1'b0, BUS_LOAD,  32'h48, 64'd0, 4'd3, 4'd3);
      tbl.push_back('{1'b0, BUS_STORE, 32'h80, 64'hAAAA, 1'b1, IDX_W'(16), 64'hBBBB, 4'd4, 4'd4});
      add(1'b0, BUS_LOAD,  32'h80, 64'd0, 4'd4, 4'd4);
      add(1'b0, BUS_LOAD,  32'hF000_2040, 64'd0, 4'd5, 4'd5);
      idle(22);
      // reset with loads in flight
      add(1'b1, BUS_NONE, 32'd0, 64'd0, 4'd0, 4'd0);
      for (int i = 0; i < 5; i++) add(1'b0, BUS_LOAD, 32'(i * 8), 64'd0, 4'(i + 1), 4'(i + 1));
      idle(3);
      add(1'b1, BUS_LOAD, 32'h18, 64'd0, 4'd0, 4'd0);
      add(1'b0, BUS_LOAD, 32'h18, 64'd0, 4'd1, 4'd1);
      idle(22);

      // preload lines 0..63 while held in reset
      for (int i = 0; i < 64; i++) begin
         @(posedge clock); #1;
         init_we   = 1'b1;
         init_addr = IDX_W'(i);
         init_data = (i == 3) ? 64'hDEAD_BEEF_0000_0003 : {32'hC0DE_0000 | 32'(i), 32'(i * 32'h0101_0101)};
      end
      @(posedge clock); #1;
      init_we = 1'b0;
      @(negedge clock);
      check("rst_resp_a", bus_a.mem2proc_response, 64'd0);
      check("rst_tag_a",  bus_a.mem2proc_tag, 64'd0);
      check("rst_data_a", bus_a.mem2proc_data, 64'd0);
      check("rst_tag_b",  bus_b.mem2proc_tag, 64'd0);
      check("rst_data_b", bus_b.mem2proc_data, 64'd0);

      foreach (tbl[i]) begin
         v = tbl[i];
         @(posedge clock); #1;
         reset = v.rst; cmd = v.cmd; addr = v.addr; wdata = v.data;
         init_we = v.iwe; init_addr = v.iaddr; init_data = v.idata;
         @(negedge clock);
`ifndef MEM_REJECT_EN
         check($sformatf("vec%0d_resp_a", i), bus_a.mem2proc_response, v.exp_a);
         check($sformatf("vec%0d_resp_b", i), bus_b.mem2proc_response, v.exp_b);
`endif
      end

      // random loads every cycle; rejects come from exhaustion or the LFSR
      @(posedge clock); #1;
      reset = 1'b1; cmd = BUS_NONE; init_we = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         cmd  = BUS_LOAD;
         addr = 32'($urandom_range(0, 63) * 8);
         @(posedge clock); #1;
      end
      cmd = BUS_NONE;
      repeat (25) @(posedge clock);
      #1;
      check("drained_a", 64'(sbq[0].size()), 64'd0);
      check("drained_b", 64'(sbq[1].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
